// File: rtl/sequenciador_quadro_verde.sv
// Camera 4:2:2 frame sequencer for the green detector:
// pixel strobes out, per-frame green count and bounding box back.
module sequenciador_quadro_verde #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MIN_PIX  = 64
) (
    input  logic        PCLK,
    input  logic        reset_n,
    input  logic        habilita,
    input  logic        VSYNC,
    input  logic        HREF,
    input  logic [7:0]  D,
    output logic        e_pix,
    output logic [7:0]  Y,
    output logic [7:0]  Cb,
    output logic [7:0]  Cr,
    input  logic        eh_verde,
    output logic        ocupado,
    output logic        frame_done,
    output logic [18:0] qtd_verde,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [8:0]  y_min,
    output logic [8:0]  y_max,
    output logic        alvo_valido
);

    localparam logic [9:0]  L_H   = 10'(H_ACTIVE);
    localparam logic [8:0]  L_V   = 9'(V_ACTIVE);
    localparam logic [18:0] L_MIN = 19'(MIN_PIX);

    typedef enum logic [2:0] {
        S_IDLE, S_VS_ALTO, S_FRAME, S_FLUSH, S_PUBLICA
    } estado_t;

    estado_t r_est, w_prox;

    logic        r_vs, r_vs_d, r_hr, r_hr_d;
    logic [7:0]  r_d, r_cb, r_y0;
    logic [1:0]  r_ph;
    logic [9:0]  r_x, r_px, r_dx;
    logic [8:0]  r_y, r_py, r_dy;
    logic        r_vd;
    logic [18:0] r_cnt;
    logic [9:0]  r_xmin, r_xmax;
    logic [8:0]  r_ymin, r_ymax;

    logic w_vs_rise, w_vs_fall, w_hr_fall;
    logic w_clear, w_cap, w_linha, w_pub, w_ok, w_strobe;

    assign w_vs_rise = r_vs & ~r_vs_d;
    assign w_vs_fall = ~r_vs & r_vs_d;
    assign w_hr_fall = ~r_hr & r_hr_d;
    assign w_ok      = (r_x < L_H) && (r_y < L_V);
    assign w_strobe  = w_cap & r_ph[1] & w_ok;

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
            r_hr   <= 1'b0;
            r_hr_d <= 1'b0;
            r_d    <= 8'd0;
        end else begin
            r_vs   <= VSYNC;
            r_vs_d <= r_vs;
            r_hr   <= HREF;
            r_hr_d <= r_hr;
            r_d    <= D;
        end
    end

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) r_est <= S_IDLE;
        else          r_est <= w_prox;
    end

    always_comb begin
        w_prox = r_est;
        unique case (r_est)
            S_IDLE:    if (w_vs_rise) w_prox = S_VS_ALTO;
            S_VS_ALTO: if (w_vs_fall) w_prox = habilita ? S_FRAME : S_IDLE;
            S_FRAME:   if (w_vs_rise) w_prox = S_FLUSH;
            S_FLUSH:   w_prox = S_PUBLICA;
            S_PUBLICA: w_prox = S_VS_ALTO;
            default:   w_prox = S_IDLE;
        endcase
    end

    // No capture on the VSYNC-rise cycle: its strobe would land after FLUSH.
    always_comb begin
        ocupado = (r_est == S_FRAME) || (r_est == S_FLUSH);
        w_clear = (r_est == S_VS_ALTO) && w_vs_fall && habilita;
        w_cap   = (r_est == S_FRAME) && r_hr && !w_vs_rise;
        w_linha = (r_est == S_FRAME) && w_hr_fall;
        w_pub   = (r_est == S_PUBLICA);
    end

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_ph  <= 2'd0;
            r_cb  <= 8'd0;
            r_y0  <= 8'd0;
            e_pix <= 1'b0;
            Y     <= 8'd0;
            Cb    <= 8'd0;
            Cr    <= 8'd0;
            r_x   <= 10'd0;
            r_y   <= 9'd0;
            r_px  <= 10'd0;
            r_py  <= 9'd0;
        end else begin
            e_pix <= w_strobe;
            if (w_clear) begin
                r_ph <= 2'd0;
                r_x  <= 10'd0;
                r_y  <= 9'd0;
            end else if (w_cap) begin
                r_ph <= r_ph + 2'd1;
                if (r_ph == 2'd0) r_cb <= r_d;
                if (r_ph == 2'd1) r_y0 <= r_d;
                if (w_strobe) begin
                    Y <= r_ph[0] ? r_d : r_y0;
                    if (!r_ph[0]) begin
                        Cb <= r_cb;
                        Cr <= r_d;
                    end
                    r_px <= r_x;
                    r_py <= r_y;
                    r_x  <= r_x + 10'd1;
                end
            end else begin
                r_ph <= 2'd0;
                if (w_linha && r_x != 10'd0) begin
                    r_x <= 10'd0;
                    if (r_y < L_V) r_y <= r_y + 9'd1;
                end
            end
        end
    end

    // Strobe coordinates are delayed one cycle to meet eh_verde.
    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_vd   <= 1'b0;
            r_dx   <= 10'd0;
            r_dy   <= 9'd0;
            r_cnt  <= 19'd0;
            r_xmin <= '1;
            r_xmax <= 10'd0;
            r_ymin <= '1;
            r_ymax <= 9'd0;
        end else begin
            r_vd <= e_pix;
            r_dx <= r_px;
            r_dy <= r_py;
            if (w_clear) begin
                r_cnt  <= 19'd0;
                r_xmin <= '1;
                r_xmax <= 10'd0;
                r_ymin <= '1;
                r_ymax <= 9'd0;
            end else if (r_vd && eh_verde) begin
                if (r_cnt != '1) r_cnt <= r_cnt + 19'd1;
                if (r_dx < r_xmin) r_xmin <= r_dx;
                if (r_dx > r_xmax) r_xmax <= r_dx;
                if (r_dy < r_ymin) r_ymin <= r_dy;
                if (r_dy > r_ymax) r_ymax <= r_dy;
            end
        end
    end

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            frame_done  <= 1'b0;
            qtd_verde   <= 19'd0;
            x_min       <= 10'd0;
            x_max       <= 10'd0;
            y_min       <= 9'd0;
            y_max       <= 9'd0;
            alvo_valido <= 1'b0;
        end else begin
            frame_done <= w_pub;
            if (w_pub) begin
                qtd_verde   <= r_cnt;
                alvo_valido <= (r_cnt >= L_MIN);
                if (r_cnt == 19'd0) begin
                    x_min <= 10'd0;
                    x_max <= 10'd0;
                    y_min <= 9'd0;
                    y_max <= 9'd0;
                end else begin
                    x_min <= r_xmin;
                    x_max <= r_xmax;
                    y_min <= r_ymin;
                    y_max <= r_ymax;
                end
            end
        end
    end

endmodule

// File: tb/tb_sequenciador_quadro_verde.sv
// Bench for sequenciador_quadro_verde: random frames against a
// pixel-level model of strobes and per-frame green statistics.
module tb_sequenciador_quadro_verde;

    localparam int H = 8;
    localparam int V = 10;
    localparam int MINP = 3;

    logic        PCLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        habilita = 1'b0;
    logic        VSYNC = 1'b0;
    logic        HREF = 1'b0;
    logic [7:0]  D = 8'd0;
    logic        eh_verde = 1'b0;
    logic        e_pix;
    logic [7:0]  Y, Cb, Cr;
    logic        ocupado, frame_done, alvo_valido;
    logic [18:0] qtd_verde;
    logic [9:0]  x_min, x_max;
    logic [8:0]  y_min, y_max;

    always #5 PCLK = ~PCLK;

    sequenciador_quadro_verde #(
        .H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIX(MINP)
    ) dut (
        .PCLK(PCLK), .reset_n(reset_n), .habilita(habilita),
        .VSYNC(VSYNC), .HREF(HREF), .D(D),
        .e_pix(e_pix), .Y(Y), .Cb(Cb), .Cr(Cr),
        .eh_verde(eh_verde), .ocupado(ocupado),
        .frame_done(frame_done), .qtd_verde(qtd_verde),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .alvo_valido(alvo_valido)
    );

    typedef struct packed {
        logic [31:0] c;
        logic [7:0]  y;
        logic [7:0]  cb;
        logic [7:0]  cr;
    } strb_t;

    strb_t got_q[$];
    strb_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fd_cnt = 0;
    bit noise_en = 0;
    logic ep_s = 1'b0;
    logic [7:0] y_s = 8'd0;

    logic [7:0] lb[16][32];
    int ll[16];
    int nl;

    logic [18:0] e_q = '0;
    logic [9:0]  e_xmin = '0, e_xmax = '0;
    logic [8:0]  e_ymin = '0, e_ymax = '0;
    logic        e_alvo = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        ep_s <= e_pix;
        y_s  <= Y;
        if (e_pix) got_q.push_back({32'(cyc), Y, Cb, Cr});
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    // Detector stand-in: green means luma >= 0xC0, answered one cycle late.
    task automatic tick();
        @(posedge PCLK);
        #1;
        eh_verde = ep_s ? (y_s >= 8'hC0)
                        : (noise_en && ($urandom_range(0, 3) == 0));
    endtask

    task automatic fill_line(input int l, input int len, input bit green);
        ll[l] = len;
        for (int j = 0; j < 32; j++) begin
            if (j % 2 == 1 && !green) lb[l][j] = 8'($urandom_range(0, 191));
            else                      lb[l][j] = 8'($urandom);
        end
    endtask

    task automatic drive_frame(input bit hab, input bit flip, input bit trunc);
        int my, mx, cnt, xmn, xmx, ymn, ymx, q4;
        logic [7:0] yy;
        got_q.delete();
        exp_q.delete();
        fd_cnt = 0;
        my = 0; cnt = 0; xmn = 1023; xmx = 0; ymn = 511; ymx = 0;
        habilita = hab;
        VSYNC = 1'b1;
        repeat (4) tick();
        VSYNC = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < nl; l++) begin
            mx = 0;
            for (int j = 0; j < ll[l]; j++) begin
                HREF = 1'b1;
                D = lb[l][j];
                if (j % 4 >= 2 && mx < H && my < V) begin
                    q4 = j - j % 4;
                    yy = (j % 4 == 2) ? lb[l][j-1] : lb[l][j];
                    exp_q.push_back({32'(cyc + 2), yy, lb[l][q4], lb[l][q4+2]});
                    if (yy >= 8'hC0) begin
                        cnt++;
                        if (mx < xmn) xmn = mx;
                        if (mx > xmx) xmx = mx;
                        if (my < ymn) ymn = my;
                        if (my > ymx) ymx = my;
                    end
                    mx++;
                end
                tick();
            end
            if (trunc && l == nl - 1) begin
                VSYNC = 1'b1;
                D = 8'($urandom);
                tick();
                tick();
                HREF = 1'b0;
            end else begin
                HREF = 1'b0;
                if (mx > 0 && my < V) my++;
                for (int k = 0; k < 3; k++) begin
                    D = 8'($urandom);
                    tick();
                end
            end
            if (flip && l == 0) habilita = !hab;
        end
        VSYNC = 1'b1;
        repeat (12) tick();
        if (hab) begin
            e_q    = 19'(cnt);
            e_xmin = cnt > 0 ? 10'(xmn) : 10'd0;
            e_xmax = cnt > 0 ? 10'(xmx) : 10'd0;
            e_ymin = cnt > 0 ? 9'(ymn) : 9'd0;
            e_ymax = cnt > 0 ? 9'(ymx) : 9'd0;
            e_alvo = (cnt >= MINP);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({e_pix, Y, Cb, Cr, ocupado, frame_done} !== 27'd0) begin
            bad++;
            $display("FAIL reset_io got=%h want=0", {e_pix, Y, Cb, Cr, ocupado, frame_done});
        end
        reset_n = 1'b1;
        repeat (2) tick();
        total++;
        if ({qtd_verde, x_min, x_max, y_min, y_max, alvo_valido} !== 58'd0) begin
            bad++;
            $display("FAIL reset_res got=%h want=0",
                     {qtd_verde, x_min, x_max, y_min, y_max, alvo_valido});
        end
        total++;
        if (ocupado !== 1'b0) begin
            bad++;
            $display("FAIL reset_ocupado got=%b want=0", ocupado);
        end
    endtask

    task automatic test_basic();
        logic [7:0] l0[8] = '{8'h80, 8'h64, 8'h90, 8'hA0, 8'h10, 8'h20, 8'h30, 8'h40};
        noise_en = 0;
        nl = 2;
        fill_line(0, 8, 0);
        fill_line(1, 8, 0);
        for (int j = 0; j < 8; j++) lb[0][j] = l0[j];
        drive_frame(1, 0, 0);
        total++;
        if (got_q.size() !== 8) begin
            bad++;
            $display("FAIL basic_nstrobe got=%0d want=8", got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL basic_strobe%0d got=%h want=%h", i,
                         i < got_q.size() ? got_q[i] : '0, exp_q[i]);
            end
        end
        total++;
        if ({got_q[0].y, got_q[0].cb, got_q[0].cr, got_q[1].y, got_q[1].cb, got_q[1].cr,
             got_q[2].y, got_q[2].cb, got_q[2].cr, got_q[3].y, got_q[3].cb, got_q[3].cr}
            !== 96'h648090_A08090_201030_401030) begin
            bad++;
            $display("FAIL basic_ycc got=%h %h %h %h want=648090 a08090 201030 401030",
                     got_q[0][23:0], got_q[1][23:0], got_q[2][23:0], got_q[3][23:0]);
        end
        total++;
        if (fd_cnt !== 1) begin
            bad++;
            $display("FAIL basic_frame_done got=%0d want=1", fd_cnt);
        end
        total++;
        if ({qtd_verde, x_min, x_max, y_min, y_max, alvo_valido} !== 58'd0) begin
            bad++;
            $display("FAIL basic_res got=%h want=0",
                     {qtd_verde, x_min, x_max, y_min, y_max, alvo_valido});
        end
    endtask

    task automatic test_bbox();
        noise_en = 1;
        nl = 8;
        for (int l = 0; l < 8; l++) fill_line(l, 12, 0);
        lb[1][7]  = 8'hF0;
        lb[2][11] = 8'hF0;
        lb[7][9]  = 8'hF0;
        drive_frame(1, 0, 0);
        total++;
        if ({qtd_verde, x_min, x_max, y_min, y_max, alvo_valido}
            !== {19'd3, 10'd3, 10'd5, 9'd1, 9'd7, 1'b1}) begin
            bad++;
            $display("FAIL bbox_res got=%0d %0d %0d %0d %0d %b want=3 3 5 1 7 1",
                     qtd_verde, x_min, x_max, y_min, y_max, alvo_valido);
        end
        total++;
        if (got_q.size() !== 48) begin
            bad++;
            $display("FAIL bbox_nstrobe got=%0d want=48", got_q.size());
        end
        total++;
        if (fd_cnt !== 1) begin
            bad++;
            $display("FAIL bbox_frame_done got=%0d want=1", fd_cnt);
        end
    endtask

    task automatic test_href_drop();
        noise_en = 1;
        nl = 3;
        fill_line(0, 11, 0);
        fill_line(1, 8, 0);
        fill_line(2, 6, 0);
        lb[0][9] = 8'hE0;
        lb[1][1] = 8'hD0;
        drive_frame(1, 0, 0);
        total++;
        if (got_q.size() !== 11) begin
            bad++;
            $display("FAIL drop_nstrobe got=%0d want=11", got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL drop_strobe%0d got=%h want=%h", i,
                         i < got_q.size() ? got_q[i] : '0, exp_q[i]);
            end
        end
        total++;
        if ({qtd_verde, x_min, x_max, y_min, y_max, alvo_valido}
            !== {19'd2, 10'd0, 10'd4, 9'd0, 9'd1, 1'b0}) begin
            bad++;
            $display("FAIL drop_res got=%0d %0d %0d %0d %0d %b want=2 0 4 0 1 0",
                     qtd_verde, x_min, x_max, y_min, y_max, alvo_valido);
        end
    endtask

    task automatic test_flush();
        noise_en = 0;
        nl = 2;
        fill_line(0, 8, 0);
        fill_line(1, 8, 0);
        lb[1][7] = 8'hFF;
        drive_frame(1, 0, 1);
        total++;
        if (got_q.size() !== 8 || got_q[7] !== exp_q[7]) begin
            bad++;
            $display("FAIL flush_last_strobe got=%h want=%h", got_q[7], exp_q[7]);
        end
        total++;
        if ({qtd_verde, x_min, x_max, y_min, y_max, alvo_valido}
            !== {19'd1, 10'd3, 10'd3, 9'd1, 9'd1, 1'b0}) begin
            bad++;
            $display("FAIL flush_res got=%0d %0d %0d %0d %0d %b want=1 3 3 1 1 0",
                     qtd_verde, x_min, x_max, y_min, y_max, alvo_valido);
        end
        total++;
        if (fd_cnt !== 1) begin
            bad++;
            $display("FAIL flush_frame_done got=%0d want=1", fd_cnt);
        end
    endtask

    task automatic test_habilita();
        noise_en = 1;
        nl = 4;
        for (int l = 0; l < 4; l++) fill_line(l, 12, 1);
        lb[0][1] = 8'hF8;
        drive_frame(0, 1, 0);
        total++;
        if (got_q.size() !== 0 || fd_cnt !== 0) begin
            bad++;
            $display("FAIL hab_off_activity got=%0d/%0d want=0/0", got_q.size(), fd_cnt);
        end
        total++;
        if ({qtd_verde, x_min, x_max, y_min, y_max, alvo_valido}
            !== {19'd1, 10'd3, 10'd3, 9'd1, 9'd1, 1'b0}) begin
            bad++;
            $display("FAIL hab_off_retain got=%0d %0d %0d %0d %0d %b want=1 3 3 1 1 0",
                     qtd_verde, x_min, x_max, y_min, y_max, alvo_valido);
        end
        drive_frame(1, 1, 0);
        total++;
        if (got_q.size() !== exp_q.size() || fd_cnt !== 1) begin
            bad++;
            $display("FAIL hab_flip_activity got=%0d/%0d want=%0d/1",
                     got_q.size(), fd_cnt, exp_q.size());
        end
        total++;
        if ({qtd_verde, x_min, x_max, y_min, y_max, alvo_valido}
            !== {e_q, e_xmin, e_xmax, e_ymin, e_ymax, e_alvo}) begin
            bad++;
            $display("FAIL hab_flip_res got=%h want=%h",
                     {qtd_verde, x_min, x_max, y_min, y_max, alvo_valido},
                     {e_q, e_xmin, e_xmax, e_ymin, e_ymax, e_alvo});
        end
    endtask

    task automatic test_reset_mid();
        habilita = 1'b1;
        VSYNC = 1'b1;
        repeat (3) tick();
        VSYNC = 1'b0;
        repeat (3) tick();
        for (int j = 0; j < 7; j++) begin
            HREF = 1'b1;
            D = 8'hC8;
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({e_pix, Y, Cb, Cr, ocupado, frame_done} !== 27'd0) begin
            bad++;
            $display("FAIL midreset_io got=%h want=0", {e_pix, Y, Cb, Cr, ocupado, frame_done});
        end
        total++;
        if ({qtd_verde, x_min, x_max, y_min, y_max, alvo_valido} !== 58'd0) begin
            bad++;
            $display("FAIL midreset_res got=%h want=0",
                     {qtd_verde, x_min, x_max, y_min, y_max, alvo_valido});
        end
        HREF = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        {e_q, e_xmin, e_xmax, e_ymin, e_ymax, e_alvo} = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit tr;
        noise_en = 1;
        for (int f = 0; f < 5; f++) begin
            nl = $urandom_range(1, 12);
            tr = ($urandom_range(0, 1) == 1);
            for (int l = 0; l < nl; l++) fill_line(l, $urandom_range(0, 24), 1);
            if (tr && ll[nl-1] < 4) ll[nl-1] = 4;
            drive_frame(1, ($urandom_range(0, 1) == 1), tr);
            total++;
            if (got_q.size() !== exp_q.size()) begin
                bad++;
                $display("FAIL b2b%0d_nstrobe got=%0d want=%0d", f, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL b2b%0d_strobe%0d got=%h want=%h", f, i,
                             i < got_q.size() ? got_q[i] : '0, exp_q[i]);
                end
            end
            total++;
            if (fd_cnt !== 1) begin
                bad++;
                $display("FAIL b2b%0d_frame_done got=%0d want=1", f, fd_cnt);
            end
            total++;
            if ({qtd_verde, x_min, x_max, y_min, y_max, alvo_valido}
                !== {e_q, e_xmin, e_xmax, e_ymin, e_ymax, e_alvo}) begin
                bad++;
                $display("FAIL b2b%0d_res got=%h want=%h", f,
                         {qtd_verde, x_min, x_max, y_min, y_max, alvo_valido},
                         {e_q, e_xmin, e_xmax, e_ymin, e_ymax, e_alvo});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bbox();
        test_href_drop();
        test_flush();
        test_habilita();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
